// File: rtl/ad7606_control_top_if.sv
// ad7606_control_top_if
//   Pin-level bundle between the AD7606 parallel-mode controller and
//   its ADC pins and downstream sample consumer.
//   data_in[15:0] : ADC parallel data bus DB[15:0]
//   busy          : ADC BUSY
//   clk_adc       : ADC RD strobe, active low
//   conv          : ADC CONVST, active low
//   valid         : 1-cycle result strobe
//   result[31:0]  : {first word, second word}
//   master = controller side, slave = ADC/consumer side.
interface ad7606_control_top_if;
   logic [15:0] data_in;
   logic        busy;
   logic        clk_adc;
   logic        conv;
   logic        valid;
   logic [31:0] result;

   modport master (
      input  data_in, busy,
      output clk_adc, conv, valid, result
   );

   modport slave (
      output data_in, busy,
      input  clk_adc, conv, valid, result
   );
endinterface

// File: rtl/ad7606_control_top.sv
// ad7606_control_top
//   Parallel-mode controller for an AD7606-class ADC. Periodically pulses
//   CONVST, waits for the conversion to finish, issues two RD strobes and
//   packs both 16-bit words into one 32-bit result with a 1-cycle valid.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : synchronous reset, active high (name kept from the codebase)
//     bus    : ad7606_control_top_if.master (data_in, busy, clk_adc, conv,
//              valid, result)
//   Optional feature macro: AD_BUSY_WAIT_EN
//     defined   : wait on BUSY (2-flop synchronised) high then low, with a
//                 BUSY_TIMEOUT cycle fallback
//     undefined : busy ignored, fixed T_CONV cycle wait
module ad7606_control_top #(
   parameter int unsigned SAMPLE_PERIOD = 2500,
   parameter int unsigned CONV_LOW      = 4,
   parameter int unsigned T_CONV        = 60,
   parameter int unsigned BUSY_TIMEOUT  = 255,
   parameter int unsigned RD_LOW        = 2,
   parameter int unsigned RD_HIGH       = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   ad7606_control_top_if.master bus
);

   localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int unsigned TW = 16;

   typedef enum logic [2:0] {
      IDLE, CONV, WAIT, RD0_L, RD0_H, RD1_L, DONE
   } state_t;

   state_t         state, nxt;
   logic [PW-1:0]  period_cnt;
   logic [TW-1:0]  timer;
   logic [15:0]    word0;
   logic           wait_done;
   logic           conv_q, clk_adc_q, valid_q;
   logic [31:0]    result_q;
   logic           conv_d, clk_adc_d, valid_d;

   // Free-running period counter; a start is only taken when it reads 0
   // while the FSM is idle, so wraps seen mid-sequence are skipped.
   always_ff @(posedge clk) begin
      if (rst_n)
         period_cnt <= '0;
      else if (period_cnt == PW'(SAMPLE_PERIOD - 1))
         period_cnt <= '0;
      else
         period_cnt <= period_cnt + 1'b1;
   end

`ifdef AD_BUSY_WAIT_EN
   logic busy_m, busy_s, busy_seen;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         busy_m    <= 1'b0;
         busy_s    <= 1'b0;
         busy_seen <= 1'b0;
      end else begin
         busy_m <= bus.busy;
         busy_s <= busy_m;
         if (state != WAIT)
            busy_seen <= 1'b0;
         else if (busy_s)
            busy_seen <= 1'b1;
      end
   end

   assign wait_done = (busy_seen && !busy_s) || (timer == TW'(BUSY_TIMEOUT - 1));
`else
   logic unused_busy;
   assign unused_busy = bus.busy;
   assign wait_done   = (timer == TW'(T_CONV - 1));
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (period_cnt == '0)               nxt = CONV;
         CONV:    if (timer == TW'(CONV_LOW - 1))     nxt = WAIT;
         WAIT:    if (wait_done)                      nxt = RD0_L;
         RD0_L:   if (timer == TW'(RD_LOW - 1))       nxt = RD0_H;
         RD0_H:   if (timer == TW'(RD_HIGH - 1))      nxt = RD1_L;
         RD1_L:   if (timer == TW'(RD_LOW - 1))       nxt = DONE;
         DONE:                                        nxt = IDLE;
         default:                                     nxt = IDLE;
      endcase
      // Pin levels are decoded from the next state and registered, so each
      // pin follows its state exactly with no input-to-output comb path.
      conv_d    = (nxt != CONV);
      clk_adc_d = !((nxt == RD0_L) || (nxt == RD1_L));
      valid_d   = (nxt == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         word0     <= '0;
         conv_q    <= 1'b1;
         clk_adc_q <= 1'b1;
         valid_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state     <= nxt;
         timer     <= (nxt != state) ? '0 : timer + 1'b1;
         conv_q    <= conv_d;
         clk_adc_q <= clk_adc_d;
         valid_q   <= valid_d;
         if (state == RD0_L && nxt == RD0_H)
            word0 <= bus.data_in;
         // Second word is sampled on the last RD1_L cycle straight into result.
         if (state == RD1_L && nxt == DONE)
            result_q <= {word0, bus.data_in};
      end
   end

   assign bus.conv    = conv_q;
   assign bus.clk_adc = clk_adc_q;
   assign bus.valid   = valid_q;
   assign bus.result  = result_q;

endmodule

// File: tb/tb_ad7606_control_top.sv
// tb_ad7606_control_top
//   Directed bench for ad7606_control_top: reset state, first conversion
//   timing, word packing, periodic restart with SAMPLE_PERIOD=100, and
//   reset during a read strobe.
module tb_ad7606_control_top;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   ad7606_control_top_if bus_a ();
   ad7606_control_top_if bus_b ();

   ad7606_control_top dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.master)
   );

   ad7606_control_top #(.SAMPLE_PERIOD(100)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.master)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b1;
      repeat (n) tick();
      rst_n = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus_a.data_in = 16'd1;
      bus_b.data_in = 16'd1;
      repeat (5) tick();
      vectors++;
      if ({bus_a.conv, bus_a.clk_adc, bus_a.valid} !== 3'b110) begin
         miscompares++;
         $display("FAIL reset_pins_a got=%b exp=110", {bus_a.conv, bus_a.clk_adc, bus_a.valid});
      end
      vectors++;
      if (bus_a.result !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_result_a got=%h exp=00000000", bus_a.result);
      end
      vectors++;
      if ({bus_b.conv, bus_b.clk_adc, bus_b.valid} !== 3'b110) begin
         miscompares++;
         $display("FAIL reset_pins_b got=%b exp=110", {bus_b.conv, bus_b.clk_adc, bus_b.valid});
      end
      vectors++;
      if (bus_b.result !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_result_b got=%h exp=00000000", bus_b.result);
      end
   endtask

   task automatic test_first_conversion();
      logic ec, er, ev;
      bus_a.data_in = 16'd2;
      rst_n = 1'b0;
      for (int n = 1; n <= 80; n++) begin
         tick();
         ec = !(n >= 1 && n <= 4);
         er = !((n >= 65 && n <= 66) || (n >= 69 && n <= 70));
         ev = (n == 71);
         vectors++;
         if ({bus_a.conv, bus_a.clk_adc, bus_a.valid} !== {ec, er, ev}) begin
            miscompares++;
            $display("FAIL seq_pins cycle=%0d got=%b exp=%b", n,
                     {bus_a.conv, bus_a.clk_adc, bus_a.valid}, {ec, er, ev});
         end
         if (n >= 71) begin
            vectors++;
            if (bus_a.result !== 32'h0002_0002) begin
               miscompares++;
               $display("FAIL seq_result cycle=%0d got=%h exp=00020002", n, bus_a.result);
            end
         end
         if (!bus_a.conv && !bus_a.clk_adc) begin
            miscompares++;
            $display("FAIL conv_rd_overlap cycle=%0d got=both_low exp=not_both_low", n);
         end
      end
   endtask

   task automatic test_data_switch();
      do_reset(2);
      bus_a.data_in = 16'h1234;
      for (int n = 1; n <= 72; n++) begin
         tick();
         if (n == 67) bus_a.data_in = 16'hABCD;
         if (n == 71) begin
            vectors++;
            if (bus_a.valid !== 1'b1 || bus_a.result !== 32'h1234_ABCD) begin
               miscompares++;
               $display("FAIL pack_words got=%b/%h exp=1/1234abcd", bus_a.valid, bus_a.result);
            end
         end
         if (n == 72) begin
            vectors++;
            if (bus_a.valid !== 1'b0 || bus_a.result !== 32'h1234_ABCD) begin
               miscompares++;
               $display("FAIL pack_hold got=%b/%h exp=0/1234abcd", bus_a.valid, bus_a.result);
            end
         end
      end
   endtask

   task automatic test_period();
      int   falls, valids, last_fall, first_fall;
      logic prev;
      do_reset(2);
      bus_b.data_in = 16'h5A5A;
      falls = 0; valids = 0; last_fall = 0; first_fall = 0;
      prev = bus_b.conv;
      for (int n = 1; n <= 1000; n++) begin
         tick();
         if (prev && !bus_b.conv) begin
            if (falls == 0) first_fall = n;
            else begin
               vectors++;
               if (n - last_fall !== 100) begin
                  miscompares++;
                  $display("FAIL period_spacing cycle=%0d got=%0d exp=100", n, n - last_fall);
               end
            end
            falls++;
            last_fall = n;
         end
         if (bus_b.valid) begin
            valids++;
            vectors++;
            if (bus_b.result !== 32'h5A5A_5A5A) begin
               miscompares++;
               $display("FAIL period_result cycle=%0d got=%h exp=5a5a5a5a", n, bus_b.result);
            end
         end
         prev = bus_b.conv;
      end
      vectors++;
      if (first_fall !== 1) begin
         miscompares++;
         $display("FAIL period_first got=%0d exp=1", first_fall);
      end
      vectors++;
      if (falls !== 10) begin
         miscompares++;
         $display("FAIL period_conv_count got=%0d exp=10", falls);
      end
      vectors++;
      if (valids !== 10) begin
         miscompares++;
         $display("FAIL period_valid_count got=%0d exp=10", valids);
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset(2);
      bus_a.data_in = 16'h7777;
      repeat (65) tick();
      vectors++;
      if (bus_a.clk_adc !== 1'b0) begin
         miscompares++;
         $display("FAIL midrd_in_rd0 got=%b exp=0", bus_a.clk_adc);
      end
      rst_n = 1'b1;
      tick();
      vectors++;
      if ({bus_a.conv, bus_a.clk_adc, bus_a.valid} !== 3'b110 || bus_a.result !== 32'h0) begin
         miscompares++;
         $display("FAIL midrd_abort got=%b/%h exp=110/00000000",
                  {bus_a.conv, bus_a.clk_adc, bus_a.valid}, bus_a.result);
      end
      for (int n = 0; n < 10; n++) begin
         tick();
         vectors++;
         if (bus_a.valid !== 1'b0 || bus_a.result !== 32'h0) begin
            miscompares++;
            $display("FAIL midrd_hold step=%0d got=%b/%h exp=0/00000000", n, bus_a.valid, bus_a.result);
         end
      end
      rst_n = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1;
      bus_a.data_in = '0;
      bus_a.busy    = 1'b0;
      bus_b.data_in = '0;
      bus_b.busy    = 1'b0;
      test_reset();
      test_first_conversion();
      test_data_switch();
      test_period();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
